// File: rtl/tile_row_queue.sv
// ---------------------------------------------------------------------------
// tile_row_queue : scrolling tile column, tap judging, score and game state.
// rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tile_row_queue #(
  parameter int ROWS        = 4,
  parameter int INIT_PERIOD = 25000000,
  parameter int STEP        = 2000000,
  parameter int MIN_PERIOD  = 5000000,
  parameter int SCORE_W     = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           rand_data,
  input  logic                 start,
  input  logic                 hit_valid,
  input  logic [1:0]           hit_lane,
  output logic [4*ROWS-1:0]    rows,
  output logic [SCORE_W-1:0]   score,
  output logic                 playing,
  output logic                 game_over,
  output logic                 hit_ok
);

  // At least 24 bits, widened if the start period would not fit.
  localparam int CNT_W = ($clog2(INIT_PERIOD + 1) > 24) ? $clog2(INIT_PERIOD + 1) : 24;

  localparam logic [CNT_W-1:0] C_INIT_PERIOD = CNT_W'(INIT_PERIOD);
  localparam logic [CNT_W-1:0] C_STEP        = CNT_W'(STEP);
  localparam logic [CNT_W-1:0] C_MIN_PERIOD  = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] C_SPEED_FLOOR = CNT_W'(MIN_PERIOD + STEP);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_OVER = 2'd2;

  logic [1:0]         state_q,     state_d;
  logic [4*ROWS-1:0]  rows_q,      rows_d;
  logic [SCORE_W-1:0] score_q,     score_d;
  logic               hit_ok_q,    hit_ok_d;
  logic [CNT_W-1:0]   period_q,    period_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [1:0]         last_lane_q, last_lane_d;

  logic               scroll_tick;
  logic [1:0]         cand;
  logic [1:0]         lane;
  logic [3:0]         row0;
  logic [3:0]         row0_after_tap;
  logic               tap_ok;
  logic               tap_bad;
  logic [SCORE_W-1:0] score_inc;
  logic               unused_rand;

  assign unused_rand = ^rand_data[4:3];

  function automatic logic [3:0] onehot(input logic [1:0] l);
    return 4'b0001 << l;
  endfunction

  // Never repeat the previous lane: bump by 1 or 2 when the candidate matches.
  assign cand = rand_data[1:0];
  assign lane = (cand != last_lane_q) ? cand
                                      : (cand + 2'd1 + {1'b0, rand_data[2]});

  assign row0           = rows_q[3:0];
  assign scroll_tick    = (state_q == S_PLAY) && (cnt_q >= period_q - CNT_W'(1));
  assign tap_ok         = hit_valid && (row0 != 4'b0000) && (row0 == onehot(hit_lane));
  assign tap_bad        = hit_valid && (row0 != 4'b0000) && (row0 != onehot(hit_lane));
  assign row0_after_tap = tap_ok ? 4'b0000 : row0;
  assign score_inc      = score_q + SCORE_W'(1);

  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    score_d     = score_q;
    hit_ok_d    = 1'b0;
    period_d    = period_q;
    cnt_d       = cnt_q;
    last_lane_d = last_lane_q;

    case (state_q)
      S_IDLE: begin
        rows_d = '0;
        if (start) begin
          state_d  = S_PLAY;
          score_d  = '0;
          cnt_d    = '0;
          period_d = C_INIT_PERIOD;
        end
      end

      S_OVER: begin
        if (start) begin
          state_d  = S_PLAY;
          rows_d   = '0;
          score_d  = '0;
          cnt_d    = '0;
          period_d = C_INIT_PERIOD;
        end
      end

      S_PLAY: begin
        cnt_d = scroll_tick ? '0 : cnt_q + CNT_W'(1);

        if (tap_ok) begin
          hit_ok_d = 1'b1;
          if (score_q != '1) begin
            score_d = score_inc;
            if (score_inc[3:0] == 4'h0) begin
              period_d = (period_q > C_SPEED_FLOOR) ? period_q - C_STEP : C_MIN_PERIOD;
            end
          end
        end

        // The tap is judged against row 0 before any shift this cycle.
        if (tap_bad) begin
          state_d = S_OVER;
        end else if (scroll_tick) begin
          last_lane_d = lane;
          if (row0_after_tap != 4'b0000) begin
            state_d = S_OVER;
          end else begin
            rows_d = {onehot(lane), rows_q[4*ROWS-1:4]};
          end
        end else if (tap_ok) begin
          rows_d[3:0] = 4'b0000;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rows_q      <= '0;
      score_q     <= '0;
      hit_ok_q    <= 1'b0;
      period_q    <= C_INIT_PERIOD;
      cnt_q       <= '0;
      last_lane_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      score_q     <= score_d;
      hit_ok_q    <= hit_ok_d;
      period_q    <= period_d;
      cnt_q       <= cnt_d;
      last_lane_q <= last_lane_d;
    end
  end

  assign rows      = rows_q;
  assign score     = score_q;
  assign hit_ok    = hit_ok_q;
  assign playing   = (state_q == S_PLAY);
  assign game_over = (state_q == S_OVER);

endmodule

`default_nettype wire

// File: tb/tb_tile_row_queue.sv
// ---------------------------------------------------------------------------
// tb_tile_row_queue : directed checks of scrolling, taps, misses and speed-up.
// rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_tile_row_queue;

  logic       clk = 1'b0;
  logic       rst, start, hit_valid;
  logic [4:0] rand_data;
  logic [1:0] hit_lane;

  logic [15:0] rows_a, rows_b;
  logic [9:0]  score_a, score_b;
  logic        playing_a, playing_b, game_over_a, game_over_b, hit_ok_a, hit_ok_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tile_row_queue #(.ROWS(4), .INIT_PERIOD(10), .STEP(2000000), .MIN_PERIOD(5000000), .SCORE_W(10)) dut_a (
    .clk(clk), .rst(rst), .rand_data(rand_data), .start(start), .hit_valid(hit_valid),
    .hit_lane(hit_lane), .rows(rows_a), .score(score_a), .playing(playing_a),
    .game_over(game_over_a), .hit_ok(hit_ok_a));

  tile_row_queue #(.ROWS(4), .INIT_PERIOD(100), .STEP(30), .MIN_PERIOD(50), .SCORE_W(10)) dut_b (
    .clk(clk), .rst(rst), .rand_data(rand_data), .start(start), .hit_valid(hit_valid),
    .hit_lane(hit_lane), .rows(rows_b), .score(score_b), .playing(playing_b),
    .game_over(game_over_b), .hit_ok(hit_ok_b));

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; hit_valid = 1'b0; hit_lane = 2'd0; rand_data = 5'h1f;
    step(2);
    rst = 1'b0;
    checks++; if (rows_a !== 16'h0)    begin failures++; $display("FAIL reset_rows: got %h want 0000", rows_a); end
    checks++; if (score_a !== 10'd0)   begin failures++; $display("FAIL reset_score: got %0d want 0", score_a); end
    checks++; if ({playing_a, game_over_a, hit_ok_a} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b want 000", {playing_a, game_over_a, hit_ok_a}); end
    checks++; if ({playing_b, game_over_b, hit_ok_b, rows_b, score_b} !== 29'd0) begin failures++; $display("FAIL reset_b: got %h want 0", {playing_b, game_over_b, hit_ok_b, rows_b, score_b}); end
  endtask

  task automatic test_scroll();
    start = 1'b1; step(1); start = 1'b0;
    checks++; if (playing_a !== 1'b1) begin failures++; $display("FAIL start_playing: got %b want 1", playing_a); end
    step(9);
    checks++; if (rows_a !== 16'h0000) begin failures++; $display("FAIL pre_tick_rows: got %h want 0000", rows_a); end
    step(1);
    checks++; if (rows_a !== 16'h8000) begin failures++; $display("FAIL tick1_rows: got %h want 8000", rows_a); end
    step(10);
    checks++; if (rows_a !== 16'h2800) begin failures++; $display("FAIL tick2_rows: got %h want 2800", rows_a); end
    step(10);
    checks++; if (rows_a !== 16'h8280) begin failures++; $display("FAIL tick3_rows: got %h want 8280", rows_a); end
    step(10);
    checks++; if (rows_a !== 16'h2828) begin failures++; $display("FAIL tick4_rows: got %h want 2828", rows_a); end
  endtask

  task automatic test_hit();
    hit_valid = 1'b1; hit_lane = 2'd3; step(1); hit_valid = 1'b0;
    checks++; if (hit_ok_a !== 1'b1)   begin failures++; $display("FAIL hit_ok_pulse: got %b want 1", hit_ok_a); end
    checks++; if (score_a !== 10'd1)   begin failures++; $display("FAIL hit_score: got %0d want 1", score_a); end
    checks++; if (rows_a !== 16'h2820) begin failures++; $display("FAIL hit_row0_clear: got %h want 2820", rows_a); end
    step(1);
    checks++; if (hit_ok_a !== 1'b0)   begin failures++; $display("FAIL hit_ok_single: got %b want 0", hit_ok_a); end
    step(8);
    checks++; if (rows_a !== 16'h8282) begin failures++; $display("FAIL hit_next_shift: got %h want 8282", rows_a); end
    checks++; if (playing_a !== 1'b1 || score_a !== 10'd1) begin failures++; $display("FAIL hit_still_playing: got %b/%0d want 1/1", playing_a, score_a); end
  endtask

  task automatic test_wrong_tap();
    hit_valid = 1'b1; hit_lane = 2'd3; step(1); hit_valid = 1'b0;
    checks++; if ({game_over_a, playing_a} !== 2'b10) begin failures++; $display("FAIL wrong_over: got %b want 10", {game_over_a, playing_a}); end
    checks++; if (rows_a !== 16'h8282 || score_a !== 10'd1) begin failures++; $display("FAIL wrong_frozen: got %h/%0d want 8282/1", rows_a, score_a); end
    step(12);
    checks++; if (rows_a !== 16'h8282 || score_a !== 10'd1) begin failures++; $display("FAIL over_frozen: got %h/%0d want 8282/1", rows_a, score_a); end
    hit_valid = 1'b1; hit_lane = 2'd1; step(1); hit_valid = 1'b0;
    checks++; if (score_a !== 10'd1 || hit_ok_a !== 1'b0 || game_over_a !== 1'b1) begin failures++; $display("FAIL over_tap_ignored: got %0d/%b/%b want 1/0/1", score_a, hit_ok_a, game_over_a); end
    start = 1'b1; step(1); start = 1'b0;
    checks++; if ({playing_a, game_over_a} !== 2'b10 || score_a !== 10'd0 || rows_a !== 16'h0) begin failures++; $display("FAIL restart: got %b/%0d/%h want 10/0/0000", {playing_a, game_over_a}, score_a, rows_a); end
  endtask

  task automatic test_miss();
    step(10);
    checks++; if (rows_a !== 16'h2000) begin failures++; $display("FAIL miss_tick1: got %h want 2000", rows_a); end
    step(30);
    checks++; if (rows_a !== 16'h8282) begin failures++; $display("FAIL miss_tick4: got %h want 8282", rows_a); end
    step(10);
    checks++; if (game_over_a !== 1'b1 || rows_a !== 16'h8282) begin failures++; $display("FAIL miss_over: got %b/%h want 1/8282", game_over_a, rows_a); end
  endtask

  task automatic test_tap_on_tick();
    rst = 1'b1; step(1); rst = 1'b0;
    checks++; if ({playing_a, game_over_a} !== 2'b00 || rows_a !== 16'h0) begin failures++; $display("FAIL rst_from_over: got %b/%h want 00/0000", {playing_a, game_over_a}, rows_a); end
    start = 1'b1; step(1); start = 1'b0;
    hit_valid = 1'b1; hit_lane = 2'd0; step(1); hit_valid = 1'b0;
    checks++; if (score_a !== 10'd0 || hit_ok_a !== 1'b0 || playing_a !== 1'b1) begin failures++; $display("FAIL empty_tap_ignored: got %0d/%b/%b want 0/0/1", score_a, hit_ok_a, playing_a); end
    step(39);
    checks++; if (rows_a !== 16'h2828) begin failures++; $display("FAIL tot_tick4: got %h want 2828", rows_a); end
    step(9);
    hit_valid = 1'b1; hit_lane = 2'd3; step(1); hit_valid = 1'b0;
    checks++; if (score_a !== 10'd1 || hit_ok_a !== 1'b1) begin failures++; $display("FAIL tot_score: got %0d/%b want 1/1", score_a, hit_ok_a); end
    checks++; if (game_over_a !== 1'b0 || rows_a !== 16'h8282) begin failures++; $display("FAIL tot_shift: got %b/%h want 0/8282", game_over_a, rows_a); end
  endtask

  task automatic test_speedup();
    int cnt;
    int exp_period;
    logic [3:0] exp_row0;
    rst = 1'b1; step(1); rst = 1'b0;
    start = 1'b1; step(1); start = 1'b0;
    cnt = 0;
    while (rows_b[3:0] == 4'b0000 && cnt < 1000) begin step(1); cnt++; end
    checks++; if (cnt != 400) begin failures++; $display("FAIL speed_first_tile: got %0d cycles want 400", cnt); end
    for (int n = 1; n <= 48; n++) begin
      exp_row0 = (n % 2 == 1) ? 4'b1000 : 4'b0010;
      checks++; if (rows_b[3:0] !== exp_row0) begin failures++; $display("FAIL speed_row0 tap %0d: got %b want %b", n, rows_b[3:0], exp_row0); end
      hit_valid = 1'b1; hit_lane = (n % 2 == 1) ? 2'd3 : 2'd1; step(1); hit_valid = 1'b0;
      checks++; if (score_b !== 10'(n) || hit_ok_b !== 1'b1) begin failures++; $display("FAIL speed_score tap %0d: got %0d/%b want %0d/1", n, score_b, hit_ok_b, n); end
      cnt = 1;
      while (rows_b[3:0] == 4'b0000 && cnt < 300) begin step(1); cnt++; end
      exp_period = (n < 16) ? 100 : (n < 32) ? 70 : 50;
      checks++; if (cnt != exp_period) begin failures++; $display("FAIL speed_spacing tap %0d: got %0d want %0d", n, cnt, exp_period); end
    end
    checks++; if (playing_b !== 1'b1) begin failures++; $display("FAIL speed_playing: got %b want 1", playing_b); end
    rst = 1'b1; step(1); rst = 1'b0;
    checks++; if ({playing_b, game_over_b, hit_ok_b} !== 3'b000 || rows_b !== 16'h0 || score_b !== 10'd0) begin failures++; $display("FAIL midgame_rst: got %b/%h/%0d want 000/0000/0", {playing_b, game_over_b, hit_ok_b}, rows_b, score_b); end
  endtask

  initial begin
    test_reset();
    test_scroll();
    test_hit();
    test_wrong_tap();
    test_miss();
    test_tap_on_tick();
    test_speedup();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
